// File: rtl/register_shift_universal.sv
// Universal WIDTH-bit register: hold / load / shift right / shift left, with an automatic
// WIDTH-bit serial-transfer sequencer, true and complement outputs.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | manual operation selected by mode; start launches a transfer
//   S_SHIFT | automatic transfer, one shift per enabled edge in dir_r
//   S_DONE  | transfer complete, done pulses for one cycle, q holds
module register_shift_universal #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             serial_in,
  input  logic             start,
  input  logic             direction,
  output logic [WIDTH-1:0] signal_q,
  output logic [WIDTH-1:0] signal_q_,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            dir_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_shr;
  logic [WIDTH-1:0] q_shl;

  assign q_shr = {serial_in, q[WIDTH-1:1]};
  assign q_shl = {q[WIDTH-2:0], serial_in};

  always_ff @(posedge clock) begin
    if (reset) begin
      q     <= RESET_VALUE;
      state <= S_IDLE;
      count <= '0;
      dir_r <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            if (start) begin
              dir_r <= direction;
              count <= '0;
              state <= S_SHIFT;
              busy  <= 1'b1;
            end else begin
              case (mode)
                2'b01:   q <= data;
                2'b10:   q <= q_shr;
                2'b11:   q <= q_shl;
                default: q <= q;
              endcase
            end
          end
        end
        S_SHIFT: begin
          if (enable) begin
            q     <= dir_r ? q_shl : q_shr;
            count <= count + CW'(1);
            // This edge performs the WIDTH-th shift.
            if (count == CW'(WIDTH - 1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign signal_q   = q;
  assign signal_q_  = ~q;
  assign serial_out = (state == S_SHIFT) ? (dir_r ? q[WIDTH-1] : q[0])
                                         : ((mode == 2'b11) ? q[WIDTH-1] : q[0]);

endmodule
